// File: rtl/branch_hazard_unit.sv
// Detects read-after-write hazards between a branch/jalr in decode and producers
// still in execute or memory, and stalls decode until the operand can be forwarded.
`ifndef OPCODE_SIZE
`define OPCODE_SIZE 7
`endif
`ifndef REGFILE_LOGSIZE
`define REGFILE_LOGSIZE 5
`endif
`ifndef BTYPE_OP
`define BTYPE_OP 7'b1100011
`endif
`ifndef JALR_OP
`define JALR_OP 7'b1100111
`endif

module branch_hazard_unit #(
  parameter int OPW  = `OPCODE_SIZE,
  parameter int RW   = `REGFILE_LOGSIZE,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [OPW-1:0]  opcode,
  input  logic [RW-1:0]   rs1_field,
  input  logic [RW-1:0]   rs2_field,
  input  logic [RW-1:0]   rd_field,
  input  logic            wr_en,
  input  logic            mem_rd,
  input  logic            flush,
  output logic            stall,
  output logic            bubble,
  output logic [CNTW-1:0] stall_cnt
);

  logic [RW-1:0] e_rd, m_rd;
  logic          e_wr, e_ld, m_wr, m_ld;
  logic          is_btype, is_jalr, is_br;
  logic          dep_e, dep_m, hazard;

  assign is_btype = (opcode == OPW'(`BTYPE_OP));
  assign is_jalr  = (opcode == OPW'(`JALR_OP));
  assign is_br    = is_btype | is_jalr;

  // Loads are only a hazard from memory stage; ALU results forward from there.
  always_comb begin
    dep_e = 1'b0;
    dep_m = 1'b0;
    if (e_wr && (e_rd != '0))
      dep_e = (e_rd == rs1_field) || (is_btype && (e_rd == rs2_field));
    if (m_wr && m_ld && (m_rd != '0))
      dep_m = (m_rd == rs1_field) || (is_btype && (m_rd == rs2_field));
  end

  assign hazard = is_br && (dep_e || dep_m) && !flush;
  assign stall  = hazard;
  assign bubble = hazard;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      e_rd <= '0;
      e_wr <= 1'b0;
      e_ld <= 1'b0;
      m_rd <= '0;
      m_wr <= 1'b0;
      m_ld <= 1'b0;
    end else begin
      m_rd <= e_rd;
      e_rd <= rd_field;
      if (flush) begin
        e_wr <= 1'b0;
        e_ld <= 1'b0;
        m_wr <= 1'b0;
        m_ld <= 1'b0;
      end else begin
        m_wr <= e_wr;
        m_ld <= e_ld;
        e_wr <= bubble ? 1'b0 : wr_en;
        e_ld <= bubble ? 1'b0 : mem_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNTW'(1);
  end

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Self-checking bench: directed hazard scenarios, counter saturation and reset,
// then random instruction streams checked against a slot-history reference model.
module tb_branch_hazard_unit;

  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct packed {
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } instr_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } slot_t;

  logic        clk;
  logic        nrst;
  logic [6:0]  opcode;
  logic [4:0]  rs1_field, rs2_field, rd_field;
  logic        wr_en, mem_rd, flush;
  logic        stall, bubble, stall4, bubble4;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  int checks = 0;
  int errors = 0;

  slot_t hist[$];
  int    model_cnt;
  bit    last_exp;
  int    obs_stalls;

  branch_hazard_unit #(.OPW(7), .RW(5), .CNTW(16)) dut (
    .clk(clk), .nrst(nrst), .opcode(opcode), .rs1_field(rs1_field),
    .rs2_field(rs2_field), .rd_field(rd_field), .wr_en(wr_en), .mem_rd(mem_rd),
    .flush(flush), .stall(stall), .bubble(bubble), .stall_cnt(stall_cnt)
  );

  branch_hazard_unit #(.OPW(7), .RW(5), .CNTW(4)) dut4 (
    .clk(clk), .nrst(nrst), .opcode(opcode), .rs1_field(rs1_field),
    .rs2_field(rs2_field), .rd_field(rd_field), .wr_en(wr_en), .mem_rd(mem_rd),
    .flush(flush), .stall(stall4), .bubble(bubble4), .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic instr_t mk(input logic [6:0] op, input int rd, input int rs1,
                                input int rs2, input bit wr, input bit ld);
    instr_t i;
    i.op = op; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
    i.wr = wr; i.ld = ld;
    return i;
  endfunction

  function automatic instr_t addi(input int rd, input int rs1);
    return mk(OP_ALUI, rd, rs1, 0, 1'b1, 1'b0);
  endfunction
  function automatic instr_t lw(input int rd);
    return mk(OP_LOAD, rd, 0, 0, 1'b1, 1'b1);
  endfunction
  function automatic instr_t beq(input int a, input int b);
    return mk(OP_BR, 0, a, b, 1'b0, 1'b0);
  endfunction
  function automatic instr_t nop();
    return mk(OP_ALUI, 0, 0, 0, 1'b1, 1'b0);
  endfunction

  // A producer in slot `s` blocks the branch if it writes a register the branch reads.
  function automatic bit reads(input slot_t s, input instr_t i, input bit need_ld);
    if (!s.wr || s.rd == 5'd0) return 1'b0;
    if (need_ld && !s.ld) return 1'b0;
    if (s.rd == i.rs1) return 1'b1;
    return (i.op == OP_BR) && (s.rd == i.rs2);
  endfunction

  function automatic bit model_stall(input instr_t i, input bit fl);
    bit br;
    br = (i.op == OP_BR) || (i.op == OP_JALR);
    return br && !fl && (reads(hist[0], i, 1'b0) || reads(hist[1], i, 1'b1));
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
    model_cnt = 0;
  endtask

  task automatic drive(input instr_t i, input bit fl);
    opcode = i.op; rs1_field = i.rs1; rs2_field = i.rs2; rd_field = i.rd;
    wr_en = i.wr; mem_rd = i.ld; flush = fl;
  endtask

  // One clock: drive decode, check combinational outputs mid-cycle, advance model.
  task automatic step(input instr_t i, input bit fl);
    slot_t s;
    drive(i, fl);
    last_exp = model_stall(i, fl);
    #3;
    check_output("stall", int'(stall), int'(last_exp));
    check_output("bubble", int'(bubble), int'(last_exp));
    check_output("stall_w4", int'(stall4), int'(last_exp));
    if (stall) obs_stalls++;
    @(posedge clk);
    s.rd = i.rd;
    s.wr = fl ? 1'b0 : (last_exp ? 1'b0 : i.wr);
    s.ld = fl ? 1'b0 : (last_exp ? 1'b0 : i.ld);
    if (fl) hist[0].wr = 1'b0;
    if (fl) hist[0].ld = 1'b0;
    hist.push_front(s);
    void'(hist.pop_back());
    if (last_exp) model_cnt++;
    #1;
    check_output("stall_cnt", int'(stall_cnt), (model_cnt > 65535) ? 65535 : model_cnt);
    check_output("stall_cnt_w4", int'(stall_cnt4), (model_cnt > 15) ? 15 : model_cnt);
  endtask

  // Issue one instruction, holding it in decode while the model says it must stall.
  task automatic issue(input instr_t i, input bit fl);
    for (int g = 0; g < 6; g++) begin
      step(i, fl);
      if (!last_exp) break;
    end
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    #1;
    check_output("rst_stall", int'(stall), 0);
    check_output("rst_cnt", int'(stall_cnt), 0);
    check_output("rst_cnt_w4", int'(stall_cnt4), 0);
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic scenario(input string tag, input instr_t a, input instr_t b,
                          input instr_t c, input bit use_b, input int exp_stalls);
    int base;
    issue(nop(), 1'b0);
    issue(nop(), 1'b0);
    base = int'(stall_cnt);
    obs_stalls = 0;
    issue(a, 1'b0);
    if (use_b) issue(b, 1'b0);
    issue(c, 1'b0);
    check_output(tag, obs_stalls, exp_stalls);
    check_output({tag, "_cnt"}, int'(stall_cnt) - base, exp_stalls);
  endtask

  initial begin
    instr_t r;
    nrst = 1'b1;
    drive(nop(), 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    scenario("alu_beq", addi(1, 0), nop(), beq(1, 5), 1'b0, 1);
    scenario("lw_beq", lw(3), nop(), beq(3, 0), 1'b0, 2);
    scenario("alu_gap_beq", addi(1, 0), nop(), beq(1, 2), 1'b1, 0);
    scenario("lw_gap_beq", lw(3), nop(), beq(3, 4), 1'b1, 1);
    scenario("x0_beq", addi(0, 0), nop(), beq(0, 0), 1'b0, 0);
    scenario("jalr_rs2", addi(2, 0), nop(), mk(OP_JALR, 1, 1, 2, 1'b1, 1'b0), 1'b0, 0);
    scenario("nonbranch", addi(1, 0), nop(), mk(OP_ALU, 4, 1, 1, 1'b1, 1'b0), 1'b0, 0);

    // Flush during what would be the first load-use stall cycle.
    issue(nop(), 1'b0);
    issue(nop(), 1'b0);
    obs_stalls = 0;
    step(lw(3), 1'b0);
    step(beq(3, 0), 1'b1);
    step(beq(3, 0), 1'b0);
    step(nop(), 1'b0);
    check_output("flush_no_stall", obs_stalls, 0);

    // Twenty stall cycles from zero: narrow counter pins at all-ones.
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      issue(lw(3), 1'b0);
      issue(beq(3, 0), 1'b0);
    end
    check_output("sat_w4", int'(stall_cnt4), 15);
    check_output("sat_w16", int'(stall_cnt), 20);

    // Random streams over a small register set so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: r = addi(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        1: r = lw(int'($urandom_range(0, 3)));
        2: r = beq(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        3: r = mk(OP_JALR, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'b1, 1'b0);
        default: r = mk(OP_ALU, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      endcase
      issue(r, ($urandom_range(0, 15) == 0));
    end

    // Reset asserted in the middle of a load-use stall.
    issue(nop(), 1'b0);
    step(lw(3), 1'b0);
    drive(beq(3, 0), 1'b0);
    #2;
    check_output("pre_rst_stall", int'(stall), 1);
    nrst = 1'b0;
    #1;
    check_output("midrst_stall", int'(stall), 0);
    check_output("midrst_bubble", int'(bubble), 0);
    check_output("midrst_cnt", int'(stall_cnt), 0);
    check_output("midrst_cnt_w4", int'(stall_cnt4), 0);
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    obs_stalls = 0;
    step(beq(3, 0), 1'b0);
    step(beq(3, 0), 1'b0);
    check_output("post_rst_stalls", obs_stalls, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_hazard_unit.md
BRANCH_HAZARD_UNIT -- requirements
Module: branch_hazard_unit

Interface
REQ-001 SHALL have parameter OPW, default `opcode_size, meaning opcode width.
REQ-002 SHALL have parameter RW, default `regfile_logsize, meaning register-index width.
REQ-003 SHALL have parameter CNTW, default 16, meaning stall-counter width.
REQ-004 SHALL have port clk  input  1  meaning single rising-edge clock for all state.
REQ-005 SHALL have port nrst  input  1  meaning reset, asynchronous and active-low.
REQ-006 SHALL have port opcode  input  OPW  meaning opcode of the instruction in decode.
REQ-007 SHALL have port rs1_field  input  RW  meaning source 1 of the decode instruction.
REQ-008 SHALL have port rs2_field  input  RW  meaning source 2 of the decode instruction.
REQ-009 SHALL have port rd_field  input  RW  meaning destination of the decode instruction.
REQ-010 SHALL have port wr_en  input  1  meaning decode instruction writes the register file.
REQ-011 SHALL have port mem_rd  input  1  meaning decode instruction is a load.
REQ-012 SHALL have port flush  input  1  meaning pipeline flush (mispredict or redirect).
REQ-013 SHALL have port stall  output  1  meaning hold PC and the fetch/decode register.
REQ-014 SHALL have port bubble  output  1  meaning inject a nop into the decode/execute register.
REQ-015 SHALL have port stall_cnt  output  CNTW  meaning saturating count of stall cycles.

Function
REQ-016 SHALL keep execute-stage tracking regs e_rd, e_wr, e_ld and memory-stage regs m_rd, m_wr, m_ld.
REQ-017 SHALL update each cycle: m_* <= e_*; e_* <= {rd_field, wr_en, mem_rd} when bubble=0, and e_wr <= 0, e_ld <= 0 when bubble=1.
REQ-018 SHALL, when flush=1, clear e_wr, e_ld, m_wr and m_ld at the next edge, overriding REQ-017.
REQ-019 SHALL define is_br = (opcode == `btype_op) or (opcode == `jalr_op).
REQ-020 SHALL match rs1_field for both btype and jalr, and rs2_field for btype only.
REQ-021 SHALL define dep_e = e_wr and e_rd != 0 and e_rd equals a matched source.
REQ-022 SHALL define dep_m = m_wr and m_ld and m_rd != 0 and m_rd equals a matched source.
REQ-023 SHALL drive stall = bubble = is_br and (dep_e or dep_m) and not flush, combinationally in the same cycle.
REQ-024 SHALL give an ALU producer immediately ahead of a dependent branch exactly 1 stall cycle.
REQ-025 SHALL give a load producer immediately ahead of a dependent branch exactly 2 stall cycles.
REQ-026 SHALL give a producer two or more slots ahead 0 stall cycles for ALU ops, and 0 stall cycles for loads three or more slots ahead.
REQ-027 SHALL never stall for a source or destination equal to x0.
REQ-028 SHALL never assert stall for a non-branch, non-jalr opcode.
REQ-029 SHALL increment stall_cnt on every cycle with stall=1 and saturate at all-ones, with no wrap.
REQ-030 SHALL stall a branch when dep_e and dep_m hold in the same cycle, without double-counting it in stall_cnt.

Reset
REQ-031 SHALL, while nrst=0, force all tracking regs and stall_cnt to 0 immediately, independent of clk.
REQ-032 SHALL drive stall=0 and bubble=0 throughout reset and in the first cycle after release.
REQ-033 SHALL, on reset asserted mid-stall, abandon the stall with no residual bubbles after release.

Verification
REQ-034 SHALL cover: addi x1 then beq x1,x5 back-to-back -> stall=1 for exactly 1 cycle, stall_cnt=1.
REQ-035 SHALL cover: lw x3 then beq x3,x0 -> stall=1 for 2 consecutive cycles, stall_cnt=2.
REQ-036 SHALL cover: addi x1, nop, beq x1,x2 -> stall never asserted; and lw x3, nop, beq x3,x4 -> exactly 1 stall cycle.
REQ-037 SHALL cover: addi x0 then beq x0,x0, and addi x2 then jalr x1 with rs2_field=2 -> stall never asserted.
REQ-038 SHALL cover: lw x3, beq x3 with flush=1 in the first stall cycle -> stall drops that cycle and no stall follows.
REQ-039 SHALL cover: CNTW=4 with 20 forced stall cycles -> stall_cnt holds at 15; nrst pulse mid-stall -> stall_cnt=0 and stall=0 asynchronously.
